// File: rtl/ixc_mc_ofifo_pkg.sv
// ixc_mc_ofifo_pkg: shared definitions for the DUT-to-host output FIFO packer.
//   - header bit positions of the 64-bit packet header word
//   - packer FSM state encoding
//   - lines_of(): number of 256-bit lines used by a packet of len payload words
package ixc_mc_ofifo_pkg;

    localparam int VLEN  = 0;
    localparam int TID   = 16;
    localparam int RST   = 61;
    localparam int MARKN = 62;
    localparam int MARK  = 63;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_PUBLISH
    } state_t;

    // ceil((1 + len) / 4): header plus payload, four 64-bit lanes per line.
    function automatic logic [1:0] lines_of(input logic [3:0] len);
        return 2'((len + 4'd4) >> 2);
    endfunction

endpackage

// File: rtl/ixc_mc_ofifo_linefmt.sv
// ixc_mc_ofifo_linefmt: combinational line formatter.
// Places the header and payload words of the packet stream into the four
// 64-bit lanes of line i_line; lanes past the end of the packet are zero.
//   i_hdr   header word (stream word 0)
//   i_data  payload, word k at [64k+63:64k]
//   i_len   payload length in words
//   i_line  line index within the packet (0..2)
//   o_line  formatted 256-bit line, lane 0 in [63:0]
module ixc_mc_ofifo_linefmt #(
    parameter int MAX_WORDS = 8
) (
    input  logic [63:0]            i_hdr,
    input  logic [64*MAX_WORDS-1:0] i_data,
    input  logic [3:0]             i_len,
    input  logic [1:0]             i_line,
    output logic [255:0]           o_line
);

    // Zero-extend the payload to 16 words so any 4-bit word index is legal.
    logic [15:0][63:0] w_words;
    assign w_words = 1024'(i_data);

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [3:0] w_j;   // stream word index of this lane
        logic [3:0] w_k;   // payload word index (stream index minus header)
        assign w_j = {i_line, 2'b00} + 4'(l);
        assign w_k = w_j - 4'd1;
        assign o_line[64*l +: 64] = (w_j == 4'd0)  ? i_hdr :
                                    (w_k < i_len)  ? w_words[w_k] : 64'd0;
    end

endmodule

// File: rtl/ixc_mc_ofifo_packer.sv
// ixc_mc_ofifo_packer: frames DUT call packets (header + payload) into
// 256-bit lines of a circular host-drained buffer.
//   fclk/hssResetN      clock, synchronous active-low reset
//   callValid/Ready     packet handshake; callTid, callLen, callData payload
//   hostRptr            host consumed-line pointer (with lap bit)
//   memWe/Addr/Data     buffer line write port
//   wptrPub             write pointer covering complete packets only
//   doorbell/Len        one-cycle pulse per packet with its line count
//   ovfErr              sticky protocol error
module ixc_mc_ofifo_packer
    import ixc_mc_ofifo_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int MAX_WORDS = 8
) (
    input  logic                    fclk,
    input  logic                    hssResetN,
    input  logic                    callValid,
    output logic                    callReady,
    input  logic [15:0]             callTid,
    input  logic [3:0]              callLen,
    input  logic [64*MAX_WORDS-1:0] callData,
    input  logic [ADDR_W:0]         hostRptr,
    output logic                    memWe,
    output logic [ADDR_W-1:0]       memAddr,
    output logic [255:0]            memData,
    output logic [ADDR_W:0]         wptrPub,
    output logic                    doorbell,
    output logic [1:0]              doorbellLen,
    output logic                    ovfErr
);

    localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] MIN_FREE = (ADDR_W+1)'(3);

    state_t                  r_state, w_stateNxt;
    logic [ADDR_W:0]         r_wptr, r_wptrPub;
    logic                    r_rstFlag, r_ovf;
    logic [63:0]             r_hdr;
    logic [64*MAX_WORDS-1:0] r_data;
    logic [3:0]              r_len;
    logic [1:0]              r_lines, r_lineIdx;

    logic [ADDR_W:0]         w_used, w_free, w_wptrInc;
    logic                    w_usedBad, w_lenBad, w_accept, w_lastLine;
    logic [63:0]             w_hdr;
    logic [255:0]            w_line;

    // Space check modulo 2^(ADDR_W+1); used beyond the depth means the host
    // pointer has run ahead of anything we published.
    assign w_used    = r_wptr - hostRptr;
    assign w_free    = DEPTH - w_used;
    assign w_usedBad = (w_used > DEPTH);
    assign w_lenBad  = (callLen > 4'(MAX_WORDS));
    assign w_wptrInc = r_wptr + 1'b1;
    assign w_lastLine = (r_lineIdx == 2'(r_lines - 2'd1));

    // Room for the largest packet is required regardless of callLen, so
    // callReady never depends on the request itself.
    assign callReady = hssResetN && (r_state == ST_IDLE) && !r_ovf &&
                       !w_usedBad && (w_free >= MIN_FREE);
    assign w_accept  = callValid && callReady;

    // Header is built at accept; MARK captures the lap bit of the first line.
    always_comb begin
        w_hdr              = '0;
        w_hdr[VLEN +: 16]  = {12'd0, callLen};
        w_hdr[TID +: 16]   = callTid;
        w_hdr[RST]         = r_rstFlag;
        w_hdr[MARKN]       = ~r_wptr[ADDR_W];
        w_hdr[MARK]        = r_wptr[ADDR_W];
    end

    always_comb begin
        w_stateNxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept && !w_lenBad) w_stateNxt = ST_WRITE;
            ST_WRITE:   if (w_lastLine) w_stateNxt = ST_PUBLISH;
            ST_PUBLISH: w_stateNxt = ST_IDLE;
            default:    w_stateNxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge fclk) begin
        if (!hssResetN) begin
            r_state   <= ST_IDLE;
            r_wptr    <= '0;
            r_wptrPub <= '0;
            r_rstFlag <= 1'b1;
            r_ovf     <= 1'b0;
            r_hdr     <= '0;
            r_data    <= '0;
            r_len     <= '0;
            r_lines   <= '0;
            r_lineIdx <= '0;
        end else begin
            r_state <= w_stateNxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_usedBad || (w_accept && w_lenBad)) r_ovf <= 1'b1;
                    if (w_accept && !w_lenBad) begin
                        r_hdr     <= w_hdr;
                        r_data    <= callData;
                        r_len     <= callLen;
                        r_lines   <= lines_of(callLen);
                        r_lineIdx <= '0;
                    end
                end
                ST_WRITE: begin
                    r_wptr    <= w_wptrInc;
                    r_lineIdx <= r_lineIdx + 2'd1;
                    // Publish on the last line so the new pointer is visible
                    // in the same cycle as the doorbell.
                    if (w_lastLine) r_wptrPub <= w_wptrInc;
                end
                ST_PUBLISH: r_rstFlag <= 1'b0;
                default: ;
            endcase
        end
    end

    ixc_mc_ofifo_linefmt #(.MAX_WORDS(MAX_WORDS)) u_linefmt (
        .i_hdr  (r_hdr),
        .i_data (r_data),
        .i_len  (r_len),
        .i_line (r_lineIdx),
        .o_line (w_line)
    );

    assign memWe       = (r_state == ST_WRITE);
    assign memAddr     = r_wptr[ADDR_W-1:0];
    assign memData     = memWe ? w_line : 256'd0;
    assign doorbell    = (r_state == ST_PUBLISH);
    assign doorbellLen = doorbell ? r_lines : 2'd0;
    assign wptrPub     = r_wptrPub;
    assign ovfErr      = r_ovf;

endmodule

// File: tb/tb_ixc_mc_ofifo_packer.sv
// Directed bench for ixc_mc_ofifo_packer, built with a 1024-line buffer so
// the full/wrap cases are reached quickly.
module tb_ixc_mc_ofifo_packer;

    localparam int AW = 10;
    localparam int MW = 8;

    logic            fclk = 1'b0;
    logic            hssResetN;
    logic            callValid;
    logic            callReady;
    logic [15:0]     callTid;
    logic [3:0]      callLen;
    logic [64*MW-1:0] callData;
    logic [AW:0]     hostRptr;
    logic            memWe;
    logic [AW-1:0]   memAddr;
    logic [255:0]    memData;
    logic [AW:0]     wptrPub;
    logic            doorbell;
    logic [1:0]      doorbellLen;
    logic            ovfErr;

    int n_assert = 0;
    int n_fail   = 0;
    int n_db     = 0;

    always #5 fclk = ~fclk;

    ixc_mc_ofifo_packer #(.ADDR_W(AW), .MAX_WORDS(MW)) dut (
        .fclk(fclk), .hssResetN(hssResetN),
        .callValid(callValid), .callReady(callReady),
        .callTid(callTid), .callLen(callLen), .callData(callData),
        .hostRptr(hostRptr),
        .memWe(memWe), .memAddr(memAddr), .memData(memData),
        .wptrPub(wptrPub), .doorbell(doorbell), .doorbellLen(doorbellLen),
        .ovfErr(ovfErr)
    );

    always @(negedge fclk) if (doorbell === 1'b1) n_db++;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [AW-1:0] addr,
                            input logic [63:0] l3, input logic [63:0] l2,
                            input logic [63:0] l1, input logic [63:0] l0);
        chk({tag, "_we"}, 256'(memWe), 256'(1'b1));
        chk({tag, "_addr"}, 256'(memAddr), 256'(addr));
        chk({tag, "_data"}, memData, {l3, l2, l1, l0});
    endtask

    // Presents a packet and returns #1 after the accepting edge (cycle N+1).
    task automatic send(input logic [15:0] tid, input logic [3:0] len, input logic [64*MW-1:0] d);
        int n;
        n = 0;
        @(posedge fclk); #1;
        callTid = tid; callLen = len; callData = d; callValid = 1'b1;
        @(negedge fclk);
        while (callReady !== 1'b1 && n < 100) begin
            @(negedge fclk);
            n++;
        end
        chk("send_ready", 256'(callReady), 256'(1'b1));
        @(posedge fclk); #1;
        callValid = 1'b0;
    endtask

    task automatic wait_db();
        int n;
        n = 0;
        @(negedge fclk);
        while (doorbell !== 1'b1 && n < 10) begin
            @(negedge fclk);
            n++;
        end
        chk("doorbell_seen", 256'(doorbell), 256'(1'b1));
    endtask

    logic [64*MW-1:0] d;
    int db_before;

    initial begin
        hssResetN = 1'b0; callValid = 1'b0; callTid = '0; callLen = '0;
        callData = '0; hostRptr = '0;

        // Reset state
        repeat (3) @(posedge fclk);
        @(negedge fclk);
        chk("rst_ready",  256'(callReady),   256'(0));
        chk("rst_we",     256'(memWe),       256'(0));
        chk("rst_addr",   256'(memAddr),     256'(0));
        chk("rst_data",   memData,           256'(0));
        chk("rst_wptr",   256'(wptrPub),     256'(0));
        chk("rst_db",     256'(doorbell),    256'(0));
        chk("rst_dblen",  256'(doorbellLen), 256'(0));
        chk("rst_ovf",    256'(ovfErr),      256'(0));
        @(posedge fclk); #1 hssResetN = 1'b1;
        @(negedge fclk);
        chk("idle_ready", 256'(callReady), 256'(1));

        // Packet 1: tid 5, len 2 -> one line at 0, RST=1 MARKN=1
        d = '0;
        d[63:0]   = 64'hAAAA_0000_0000_000A;
        d[127:64] = 64'hBBBB_0000_0000_000B;
        send(16'h0005, 4'd2, d);
        @(negedge fclk);
        chk_line("p1_l0", 0, 64'd0, 64'hBBBB_0000_0000_000B,
                 64'hAAAA_0000_0000_000A, 64'h6000_0000_0005_0002);
        chk("p1_busy_ready", 256'(callReady), 256'(0));
        chk("p1_no_db", 256'(doorbell), 256'(0));
        @(negedge fclk);
        chk("p1_db", 256'(doorbell), 256'(1));
        chk("p1_dblen", 256'(doorbellLen), 256'(1));
        chk("p1_wptr", 256'(wptrPub), 256'(1));
        chk("p1_we_off", 256'(memWe), 256'(0));

        // Packet 2: tid 6, len 8 -> three lines at 1..3, RST=0
        for (int k = 0; k < 8; k++) d[64*k +: 64] = 64'h1000 + 64'(k);
        send(16'h0006, 4'd8, d);
        @(negedge fclk);
        chk_line("p2_l0", 1, 64'h1002, 64'h1001, 64'h1000, 64'h4000_0000_0006_0008);
        @(negedge fclk);
        chk_line("p2_l1", 2, 64'h1006, 64'h1005, 64'h1004, 64'h1003);
        @(negedge fclk);
        chk_line("p2_l2", 3, 64'd0, 64'd0, 64'd0, 64'h1007);
        @(negedge fclk);
        chk("p2_db", 256'(doorbell), 256'(1));
        chk("p2_dblen", 256'(doorbellLen), 256'(3));
        chk("p2_wptr", 256'(wptrPub), 256'(4));

        // Fill to 2^AW-2 with hostRptr held at 0
        for (int p = 0; p < 338; p++) send(16'h0100, 4'd8, d);
        send(16'h0101, 4'd4, d);
        send(16'h0102, 4'd4, d);
        wait_db();
        chk("fill_wptr", 256'(wptrPub), 256'((1 << AW) - 2));
        chk("fill_dblen", 256'(doorbellLen), 256'(2));

        // Back-pressure: free = 2 blocks, one more consumed line releases
        @(posedge fclk); #1;
        @(negedge fclk);
        chk("full_ready", 256'(callReady), 256'(0));
        repeat (3) @(negedge fclk);
        chk("full_ready_hold", 256'(callReady), 256'(0));
        chk("full_no_we", 256'(memWe), 256'(0));
        @(posedge fclk); #1 hostRptr = 11'd1;
        @(posedge fclk); #1;
        @(negedge fclk);
        chk("unblock_ready", 256'(callReady), 256'(1));
        hostRptr = 11'd8;

        // len 0: header-only line at 0x3FE
        send(16'h0007, 4'd0, d);
        @(negedge fclk);
        chk_line("z_l0", 10'h3FE, 64'd0, 64'd0, 64'd0, 64'h4000_0000_0007_0000);
        @(negedge fclk);
        chk("z_dblen", 256'(doorbellLen), 256'(1));

        // Wrap: len 5 from 0x3FF spills into line 0, lap bit toggles
        d = '0;
        for (int k = 0; k < 5; k++) d[64*k +: 64] = 64'h2000 + 64'(k);
        send(16'h0008, 4'd5, d);
        @(negedge fclk);
        chk_line("w_l0", 10'h3FF, 64'h2002, 64'h2001, 64'h2000, 64'h4000_0000_0008_0005);
        @(negedge fclk);
        chk_line("w_l1", 10'h000, 64'd0, 64'd0, 64'h2004, 64'h2003);
        @(negedge fclk);
        chk("w_db", 256'(doorbell), 256'(1));
        chk("w_dblen", 256'(doorbellLen), 256'(2));
        chk("w_wptr", 256'(wptrPub), 256'(11'h401));

        send(16'h0009, 4'd0, d);
        @(negedge fclk);
        chk_line("m_l0", 10'h001, 64'd0, 64'd0, 64'd0, 64'h8000_0000_0009_0000);
        @(negedge fclk);
        chk("m_wptr", 256'(wptrPub), 256'(11'h402));

        // Over-length packet is dropped and latches ovfErr
        send(16'h000A, 4'd12, d);
        @(negedge fclk);
        chk("ovf_no_we", 256'(memWe), 256'(0));
        chk("ovf_flag", 256'(ovfErr), 256'(1));
        chk("ovf_ready", 256'(callReady), 256'(0));
        repeat (4) @(negedge fclk);
        chk("ovf_sticky", 256'(ovfErr), 256'(1));
        chk("ovf_ready_hold", 256'(callReady), 256'(0));
        chk("ovf_wptr", 256'(wptrPub), 256'(11'h402));

        // Reset mid-packet abandons it; next packet restarts at 0 with RST=1
        @(posedge fclk); #1 hssResetN = 1'b0;
        @(posedge fclk); #1 hssResetN = 1'b1;
        hostRptr = '0;
        @(negedge fclk);
        chk("rst2_ovf", 256'(ovfErr), 256'(0));
        for (int k = 0; k < 8; k++) d[64*k +: 64] = 64'h3000 + 64'(k);
        send(16'h000B, 4'd8, d);
        @(negedge fclk);
        chk_line("r_l0", 0, 64'h3002, 64'h3001, 64'h3000, 64'h6000_0000_000B_0008);
        db_before = n_db;
        @(posedge fclk); #1 hssResetN = 1'b0;
        @(negedge fclk);
        chk("r_l1_addr", 256'(memAddr), 256'(1));
        @(negedge fclk);
        chk("r_we_off", 256'(memWe), 256'(0));
        chk("r_wptr0", 256'(wptrPub), 256'(0));
        @(posedge fclk); #1 hssResetN = 1'b1;
        repeat (3) @(negedge fclk);
        chk("r_no_db", 256'(n_db), 256'(db_before));
        d = '0;
        d[63:0] = 64'h77;
        send(16'h000C, 4'd1, d);
        @(negedge fclk);
        chk_line("r2_l0", 0, 64'd0, 64'd0, 64'h77, 64'h6000_0000_000C_0001);
        @(negedge fclk);
        chk("r2_db", 256'(doorbell), 256'(1));
        chk("r2_wptr", 256'(wptrPub), 256'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
